brq_wbq: RTL and testbench

Multi-entry, in-order writeback queue that succeeds the single-entry writeback stage. It sits between ID/EX and the integer/FP register files. It accepts one instruction per cycle and tracks up to `Depth` in-flight instructions, so several loads or stores can await LSU responses at once. Instructions retire strictly in order, at most one per cycle. The block also supplies per-register pending masks to the ID/EX hazard logic.

---
 rtl/brq_pkg.sv | 37 +++
 rtl/brq_wbq_ptrs.sv | 51 +++++
 rtl/brq_wbq.sv | 221 ++++++++++++++++++++++
 tb/tb_brq_wbq.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brq_pkg.sv
// Shared types for the in-order writeback queue.
// BRQ_WBQ_PERF_EN adds the per-entry PC / compressed / count fields used for retirement tracing.
package brq_pkg;

  typedef enum logic [1:0] {
    WB_INSTR_LOAD  = 2'b00,
    WB_INSTR_STORE = 2'b01,
    WB_INSTR_OTHER = 2'b10
  } wb_instr_type_e;

  localparam int unsigned WBQ_DEPTH_DEFAULT = 2;

  typedef struct packed {
    logic           valid;
    wb_instr_type_e instr_type;
    logic           done;
    logic           err;
    logic           is_fp;
    logic           we;
    logic [4:0]     waddr;
    logic [31:0]    wdata;
`ifdef BRQ_WBQ_PERF_EN
    logic [31:0]    pc;
    logic           compressed;
    logic           count;
`endif
  } wbq_entry_t;

  // Circular-buffer index arithmetic for depths that need not be powers of two.
  function automatic int unsigned wbq_idx_add(input int unsigned base, input int unsigned off,
                                              input int unsigned depth);
    int unsigned sum;
    sum = base + off;
    return (sum >= depth) ? (sum - depth) : sum;
  endfunction

endpackage

// File: rtl/brq_wbq_ptrs.sv
// Head/tail pointers and occupancy count for the writeback queue.
// A pop frees a slot in the same cycle, so a full queue can still accept a push.
module brq_wbq_ptrs #(
  parameter int unsigned Depth = 2,
  parameter int unsigned IdxW  = 1,
  parameter int unsigned CntW  = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            i_push,
  input  logic            i_pop,
  output logic [IdxW-1:0] o_head_idx,
  output logic [IdxW-1:0] o_tail_idx,
  output logic [CntW-1:0] o_count,
  output logic            o_full,
  output logic            o_empty,
  output logic            o_ready
);

  logic [IdxW-1:0] r_head;
  logic [IdxW-1:0] r_tail;
  logic [CntW-1:0] r_count;

  function automatic logic [IdxW-1:0] f_wrap_inc(input logic [IdxW-1:0] idx);
    return (idx == IdxW'(Depth - 1)) ? '0 : (idx + IdxW'(1));
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_tail <= f_wrap_inc(r_tail);
      end
      if (i_pop) begin
        r_head <= f_wrap_inc(r_head);
      end
      r_count <= r_count + CntW'(i_push) - CntW'(i_pop);
    end
  end

  assign o_head_idx = r_head;
  assign o_tail_idx = r_tail;
  assign o_count    = r_count;
  assign o_full     = (r_count == CntW'(Depth));
  assign o_empty    = (r_count == '0);
  assign o_ready    = ~o_full | i_pop;

endmodule

// File: rtl/brq_wbq.sv
// In-order multi-entry writeback queue between ID/EX and the integer/FP register files.
// Optional BRQ_WBQ_PERF_EN enables per-entry PC/perf tracking and the pc/perf outputs.
module brq_wbq
  import brq_pkg::*;
#(
  parameter int unsigned Depth = WBQ_DEPTH_DEFAULT
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           en_wb_i,
  input  wb_instr_type_e instr_type_wb_i,
  input  logic [31:0]    pc_id_i,
  input  logic           instr_is_compressed_id_i,
  input  logic           instr_perf_count_id_i,
  input  logic [4:0]     rf_waddr_id_i,
  input  logic [31:0]    rf_wdata_id_i,
  input  logic           rf_we_id_i,
  input  logic           fp_rf_we_id_i,
  output logic           ready_wb_o,
  input  logic           lsu_resp_valid_i,
  input  logic           lsu_resp_err_i,
  input  logic           rf_we_lsu_i,
  input  logic [31:0]    rf_wdata_lsu_i,
  output logic [4:0]     rf_waddr_wb_o,
  output logic [31:0]    rf_wdata_wb_o,
  output logic           rf_we_wb_o,
  output logic           fp_rf_we_wb_o,
  output logic [31:0]    rf_pending_o,
  output logic [31:0]    fp_rf_pending_o,
  output logic [31:0]    rf_wdata_fwd_wb_o,
  output logic           outstanding_load_wb_o,
  output logic           outstanding_store_wb_o,
  output logic           instr_done_wb_o,
  output logic [31:0]    pc_wb_o,
  output logic           perf_instr_ret_wb_o,
  output logic           perf_instr_ret_compressed_wb_o
);

  localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  wbq_entry_t      r_q [Depth];
  wbq_entry_t      w_head;
  wbq_entry_t      w_new;
  logic [IdxW-1:0] w_head_idx;
  logic [IdxW-1:0] w_tail_idx;
  logic [IdxW-1:0] w_match_idx;
  logic [CntW-1:0] w_count;
  logic            w_full;
  logic            w_empty;
  logic            w_ready;
  logic            w_push;
  logic            w_retire;
  logic            w_match_found;
  logic            w_resp_match;
  logic            w_resp_head;
  logic            w_head_we;
  logic [31:0]     w_head_wdata;
  logic [31:0]     w_rf_pend;
  logic [31:0]     w_fp_pend;
  logic [31:0]     w_ent_rf_pend [Depth];
  logic [31:0]     w_ent_fp_pend [Depth];
  logic [Depth-1:0] w_ent_ld_out;
  logic [Depth-1:0] w_ent_st_out;

  brq_wbq_ptrs #(
    .Depth (Depth),
    .IdxW  (IdxW),
    .CntW  (CntW)
  ) u_ptrs (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_push     (w_push),
    .i_pop      (w_retire),
    .o_head_idx (w_head_idx),
    .o_tail_idx (w_tail_idx),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_ready    (w_ready)
  );

  assign w_push     = en_wb_i & w_ready;
  assign ready_wb_o = w_ready;

  always_comb begin
    w_new            = '0;
    w_new.valid      = 1'b1;
    w_new.instr_type = instr_type_wb_i;
    w_new.is_fp      = fp_rf_we_id_i;
    w_new.waddr      = rf_waddr_id_i;
    w_new.wdata      = rf_wdata_id_i;
    if (instr_type_wb_i == WB_INSTR_OTHER) begin
      w_new.done = 1'b1;
      w_new.we   = rf_we_id_i | fp_rf_we_id_i;
    end
`ifdef BRQ_WBQ_PERF_EN
    w_new.pc         = pc_id_i;
    w_new.compressed = instr_is_compressed_id_i;
    w_new.count      = instr_perf_count_id_i;
`endif
  end

  // Responses arrive in request order, so the oldest unfinished LSU entry owns each one.
  always_comb begin
    int unsigned idx;
    w_match_found = 1'b0;
    w_match_idx   = '0;
    for (int unsigned k = 0; k < Depth; k++) begin
      idx = wbq_idx_add(32'(w_head_idx), k, Depth);
      if (!w_match_found && r_q[idx].valid && !r_q[idx].done &&
          (r_q[idx].instr_type != WB_INSTR_OTHER)) begin
        w_match_found = 1'b1;
        w_match_idx   = IdxW'(idx);
      end
    end
  end

  assign w_head       = r_q[w_head_idx];
  assign w_resp_match = lsu_resp_valid_i & w_match_found;
  assign w_resp_head  = w_resp_match & (w_match_idx == w_head_idx);
  assign w_retire     = w_head.valid & (w_head.done | w_resp_head);

  assign w_head_we    = w_resp_head ?
                        ((w_head.instr_type == WB_INSTR_LOAD) & rf_we_lsu_i & ~lsu_resp_err_i) :
                        w_head.we;
  assign w_head_wdata = w_resp_head ? rf_wdata_lsu_i : w_head.wdata;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      if (w_retire) begin
        r_q[w_head_idx].valid <= 1'b0;
      end
      if (w_resp_match && !w_resp_head) begin
        r_q[w_match_idx].done  <= 1'b1;
        r_q[w_match_idx].err   <= lsu_resp_err_i;
        r_q[w_match_idx].we    <= (r_q[w_match_idx].instr_type == WB_INSTR_LOAD) &
                                  rf_we_lsu_i & ~lsu_resp_err_i;
        r_q[w_match_idx].wdata <= rf_wdata_lsu_i;
      end
      // Applied last: when full and retiring, the tail slot is the slot being vacated.
      if (w_push) begin
        r_q[w_tail_idx] <= w_new;
      end
    end
  end

  for (genvar gi = 0; gi < Depth; gi++) begin : g_ent
    logic w_writes;
    assign w_writes = r_q[gi].valid &
                      (r_q[gi].we | ((r_q[gi].instr_type == WB_INSTR_LOAD) & ~r_q[gi].done));
    assign w_ent_rf_pend[gi] = (w_writes & ~r_q[gi].is_fp) ? (32'd1 << r_q[gi].waddr) : '0;
    assign w_ent_fp_pend[gi] = (w_writes &  r_q[gi].is_fp) ? (32'd1 << r_q[gi].waddr) : '0;
    assign w_ent_ld_out[gi]  = r_q[gi].valid & ~r_q[gi].done &
                               (r_q[gi].instr_type == WB_INSTR_LOAD);
    assign w_ent_st_out[gi]  = r_q[gi].valid & ~r_q[gi].done &
                               (r_q[gi].instr_type == WB_INSTR_STORE);
  end

  always_comb begin
    w_rf_pend = '0;
    w_fp_pend = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      w_rf_pend = w_rf_pend | w_ent_rf_pend[i];
      w_fp_pend = w_fp_pend | w_ent_fp_pend[i];
    end
  end

  assign rf_pending_o           = w_rf_pend & ~32'd1;
  assign fp_rf_pending_o        = w_fp_pend;
  assign outstanding_load_wb_o  = |w_ent_ld_out;
  assign outstanding_store_wb_o = |w_ent_st_out;

  assign instr_done_wb_o   = w_retire;
  assign rf_we_wb_o        = w_retire & w_head_we & ~w_head.is_fp;
  assign fp_rf_we_wb_o     = w_retire & w_head_we &  w_head.is_fp;
  assign rf_waddr_wb_o     = w_head.valid ? w_head.waddr : '0;
  assign rf_wdata_wb_o     = w_head.valid ? w_head_wdata : '0;
  assign rf_wdata_fwd_wb_o = w_head.valid ? w_head.wdata : '0;

`ifdef BRQ_WBQ_PERF_EN
  logic w_head_err;
  assign w_head_err                     = w_resp_head ? lsu_resp_err_i : w_head.err;
  assign pc_wb_o                        = w_head.valid ? w_head.pc : '0;
  assign perf_instr_ret_wb_o            = w_retire & w_head.count & ~w_head_err;
  assign perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & w_head.compressed;
`else
  logic w_unused_perf;
  assign w_unused_perf                  = ^{pc_id_i, instr_is_compressed_id_i, instr_perf_count_id_i};
  assign pc_wb_o                        = '0;
  assign perf_instr_ret_wb_o            = 1'b0;
  assign perf_instr_ret_compressed_wb_o = 1'b0;
`endif

  logic w_unused_occ;
  assign w_unused_occ = ^{w_count, w_full, w_empty};

`ifndef SYNTHESIS
  // Responses left over from before a reset are legal until the next enqueue.
  logic r_flush;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_flush <= 1'b1;
    end else if (w_push) begin
      r_flush <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && lsu_resp_valid_i && !r_flush) begin
      assert (w_match_found)
        else $error("brq_wbq: LSU response with no outstanding LSU entry");
    end
  end
`endif

endmodule

// File: tb/tb_brq_wbq.sv
// Directed bench for brq_wbq (Depth=2); perf/pc expectations follow BRQ_WBQ_PERF_EN.
module tb_brq_wbq;
  import brq_pkg::*;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           en_wb_i;
  wb_instr_type_e instr_type_wb_i;
  logic [31:0]    pc_id_i;
  logic           instr_is_compressed_id_i;
  logic           instr_perf_count_id_i;
  logic [4:0]     rf_waddr_id_i;
  logic [31:0]    rf_wdata_id_i;
  logic           rf_we_id_i;
  logic           fp_rf_we_id_i;
  logic           ready_wb_o;
  logic           lsu_resp_valid_i;
  logic           lsu_resp_err_i;
  logic           rf_we_lsu_i;
  logic [31:0]    rf_wdata_lsu_i;
  logic [4:0]     rf_waddr_wb_o;
  logic [31:0]    rf_wdata_wb_o;
  logic           rf_we_wb_o;
  logic           fp_rf_we_wb_o;
  logic [31:0]    rf_pending_o;
  logic [31:0]    fp_rf_pending_o;
  logic [31:0]    rf_wdata_fwd_wb_o;
  logic           outstanding_load_wb_o;
  logic           outstanding_store_wb_o;
  logic           instr_done_wb_o;
  logic [31:0]    pc_wb_o;
  logic           perf_instr_ret_wb_o;
  logic           perf_instr_ret_compressed_wb_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  brq_wbq dut (
    .clk_i                          (clk_i),
    .rst_ni                         (rst_ni),
    .en_wb_i                        (en_wb_i),
    .instr_type_wb_i                (instr_type_wb_i),
    .pc_id_i                        (pc_id_i),
    .instr_is_compressed_id_i       (instr_is_compressed_id_i),
    .instr_perf_count_id_i          (instr_perf_count_id_i),
    .rf_waddr_id_i                  (rf_waddr_id_i),
    .rf_wdata_id_i                  (rf_wdata_id_i),
    .rf_we_id_i                     (rf_we_id_i),
    .fp_rf_we_id_i                  (fp_rf_we_id_i),
    .ready_wb_o                     (ready_wb_o),
    .lsu_resp_valid_i               (lsu_resp_valid_i),
    .lsu_resp_err_i                 (lsu_resp_err_i),
    .rf_we_lsu_i                    (rf_we_lsu_i),
    .rf_wdata_lsu_i                 (rf_wdata_lsu_i),
    .rf_waddr_wb_o                  (rf_waddr_wb_o),
    .rf_wdata_wb_o                  (rf_wdata_wb_o),
    .rf_we_wb_o                     (rf_we_wb_o),
    .fp_rf_we_wb_o                  (fp_rf_we_wb_o),
    .rf_pending_o                   (rf_pending_o),
    .fp_rf_pending_o                (fp_rf_pending_o),
    .rf_wdata_fwd_wb_o              (rf_wdata_fwd_wb_o),
    .outstanding_load_wb_o          (outstanding_load_wb_o),
    .outstanding_store_wb_o         (outstanding_store_wb_o),
    .instr_done_wb_o                (instr_done_wb_o),
    .pc_wb_o                        (pc_wb_o),
    .perf_instr_ret_wb_o            (perf_instr_ret_wb_o),
    .perf_instr_ret_compressed_wb_o (perf_instr_ret_compressed_wb_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_perf(input string tag, input logic ret, input logic cmp,
                            input logic [31:0] pc);
`ifdef BRQ_WBQ_PERF_EN
    check_eq({tag, "_perf_ret"}, perf_instr_ret_wb_o, ret);
    check_eq({tag, "_perf_cmp"}, perf_instr_ret_compressed_wb_o, cmp);
    check_eq({tag, "_pc"}, pc_wb_o, pc);
`else
    check_eq({tag, "_perf_ret"}, perf_instr_ret_wb_o, 1'b0);
    check_eq({tag, "_perf_cmp"}, perf_instr_ret_compressed_wb_o, 1'b0);
    check_eq({tag, "_pc"}, pc_wb_o, 32'd0);
`endif
  endtask

  task automatic write_chk(input string tag, input logic we, input logic fpwe,
                           input logic [4:0] a, input logic [31:0] d);
    check_eq({tag, "_done"}, instr_done_wb_o, 1'b1);
    check_eq({tag, "_we"}, rf_we_wb_o, we);
    check_eq({tag, "_fpwe"}, fp_rf_we_wb_o, fpwe);
    check_eq({tag, "_waddr"}, rf_waddr_wb_o, a);
    check_eq({tag, "_wdata"}, rf_wdata_wb_o, d);
  endtask

  // Advance one cycle, return inputs to idle just after the edge, log the transaction.
  task automatic cyc(input string what);
    @(posedge clk_i);
    #1;
    en_wb_i                  = 1'b0;
    instr_type_wb_i          = WB_INSTR_OTHER;
    pc_id_i                  = '0;
    instr_is_compressed_id_i = 1'b0;
    instr_perf_count_id_i    = 1'b0;
    rf_waddr_id_i            = '0;
    rf_wdata_id_i            = '0;
    rf_we_id_i               = 1'b0;
    fp_rf_we_id_i            = 1'b0;
    lsu_resp_valid_i         = 1'b0;
    lsu_resp_err_i           = 1'b0;
    rf_we_lsu_i              = 1'b0;
    rf_wdata_lsu_i           = '0;
    $display("[%0t] %s", $time, what);
  endtask

  task automatic enq(input wb_instr_type_e t, input logic [4:0] a, input logic [31:0] d,
                     input logic fp, input logic [31:0] pc, input logic cmp);
    en_wb_i                  = 1'b1;
    instr_type_wb_i          = t;
    rf_waddr_id_i            = a;
    rf_wdata_id_i            = d;
    rf_we_id_i               = (t == WB_INSTR_OTHER) && !fp;
    fp_rf_we_id_i            = fp;
    pc_id_i                  = pc;
    instr_is_compressed_id_i = cmp;
    instr_perf_count_id_i    = 1'b1;
  endtask

  task automatic resp(input logic [31:0] d, input logic err);
    lsu_resp_valid_i = 1'b1;
    lsu_resp_err_i   = err;
    rf_we_lsu_i      = 1'b1;
    rf_wdata_lsu_i   = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc("reset");
    cyc("reset");
    @(negedge clk_i);
    check_eq("rst_ready", ready_wb_o, 1'b1);
    check_eq("rst_done", instr_done_wb_o, 1'b0);
    check_eq("rst_we", rf_we_wb_o, 1'b0);
    check_eq("rst_fpwe", fp_rf_we_wb_o, 1'b0);
    check_eq("rst_pend", rf_pending_o, 32'd0);
    check_eq("rst_fppend", fp_rf_pending_o, 32'd0);
    check_eq("rst_waddr", rf_waddr_wb_o, 5'd0);
    check_eq("rst_wdata", rf_wdata_wb_o, 32'd0);
    check_eq("rst_fwd", rf_wdata_fwd_wb_o, 32'd0);
    check_eq("rst_outld", outstanding_load_wb_o, 1'b0);
    check_eq("rst_outst", outstanding_store_wb_o, 1'b0);
    check_perf("rst", 1'b0, 1'b0, 32'd0);
    cyc("release reset");
    rst_ni = 1'b1;

    // Back-to-back OTHER
    cyc("enq OTHER x5");
    enq(WB_INSTR_OTHER, 5'd5, 32'd1, 1'b0, 32'h100, 1'b0);
    @(negedge clk_i);
    check_eq("b2b0_ready", ready_wb_o, 1'b1);
    check_eq("b2b0_we", rf_we_wb_o, 1'b0);
    cyc("enq OTHER x6");
    enq(WB_INSTR_OTHER, 5'd6, 32'd2, 1'b0, 32'h104, 1'b1);
    @(negedge clk_i);
    write_chk("b2b1", 1'b1, 1'b0, 5'd5, 32'd1);
    check_eq("b2b1_ready", ready_wb_o, 1'b1);
    check_eq("b2b1_pend", rf_pending_o, 32'h20);
    check_perf("b2b1", 1'b1, 1'b0, 32'h100);
    cyc("enq OTHER x7");
    enq(WB_INSTR_OTHER, 5'd7, 32'd3, 1'b0, 32'h108, 1'b0);
    @(negedge clk_i);
    write_chk("b2b2", 1'b1, 1'b0, 5'd6, 32'd2);
    check_eq("b2b2_ready", ready_wb_o, 1'b1);
    check_perf("b2b2", 1'b1, 1'b1, 32'h104);
    cyc("drain");
    @(negedge clk_i);
    write_chk("b2b3", 1'b1, 1'b0, 5'd7, 32'd3);
    cyc("idle");
    @(negedge clk_i);
    check_eq("b2b4_done", instr_done_wb_o, 1'b0);
    check_eq("b2b4_pend", rf_pending_o, 32'd0);

    // Two loads fill the queue, then an OTHER waits for space
    cyc("enq LOAD x5");
    enq(WB_INSTR_LOAD, 5'd5, 32'd0, 1'b0, 32'h200, 1'b0);
    @(negedge clk_i);
    check_eq("ll0_ready", ready_wb_o, 1'b1);
    cyc("enq LOAD x6");
    enq(WB_INSTR_LOAD, 5'd6, 32'd0, 1'b0, 32'h204, 1'b0);
    @(negedge clk_i);
    check_eq("ll1_pend", rf_pending_o, 32'h20);
    check_eq("ll1_outld", outstanding_load_wb_o, 1'b1);
    check_eq("ll1_done", instr_done_wb_o, 1'b0);
    cyc("offer OTHER x7, full");
    enq(WB_INSTR_OTHER, 5'd7, 32'h77, 1'b0, 32'h208, 1'b0);
    @(negedge clk_i);
    check_eq("ll2_ready", ready_wb_o, 1'b0);
    check_eq("ll2_pend", rf_pending_o, 32'h60);
    cyc("resp x5, OTHER x7 accepted on retire");
    enq(WB_INSTR_OTHER, 5'd7, 32'h77, 1'b0, 32'h208, 1'b0);
    resp(32'hAAAA_0001, 1'b0);
    @(negedge clk_i);
    write_chk("ll3", 1'b1, 1'b0, 5'd5, 32'hAAAA_0001);
    check_eq("ll3_ready", ready_wb_o, 1'b1);
    check_perf("ll3", 1'b1, 1'b0, 32'h200);
    cyc("idle, full");
    @(negedge clk_i);
    check_eq("ll4_ready", ready_wb_o, 1'b0);
    check_eq("ll4_pend", rf_pending_o, 32'hC0);
    check_eq("ll4_done", instr_done_wb_o, 1'b0);
    cyc("resp x6");
    resp(32'h1234_5678, 1'b0);
    @(negedge clk_i);
    write_chk("ll5", 1'b1, 1'b0, 5'd6, 32'h1234_5678);
    cyc("OTHER x7 retires");
    @(negedge clk_i);
    write_chk("ll6", 1'b1, 1'b0, 5'd7, 32'h77);
    cyc("idle");
    @(negedge clk_i);
    check_eq("ll7_pend", rf_pending_o, 32'd0);
    check_eq("ll7_outld", outstanding_load_wb_o, 1'b0);

    // Response captured by a non-head load
    cyc("enq LOAD x9");
    enq(WB_INSTR_LOAD, 5'd9, 32'd0, 1'b0, 32'h300, 1'b0);
    cyc("enq OTHER x3");
    enq(WB_INSTR_OTHER, 5'd3, 32'h33, 1'b0, 32'h304, 1'b0);
    cyc("resp x9, enq LOAD x4");
    resp(32'h99, 1'b0);
    enq(WB_INSTR_LOAD, 5'd4, 32'd0, 1'b0, 32'h308, 1'b0);
    @(negedge clk_i);
    write_chk("cap0", 1'b1, 1'b0, 5'd9, 32'h99);
    check_eq("cap0_ready", ready_wb_o, 1'b1);
    cyc("resp for x4 while x3 at head");
    resp(32'hDEAD_BEEF, 1'b0);
    @(negedge clk_i);
    write_chk("cap1", 1'b1, 1'b0, 5'd3, 32'h33);
    check_eq("cap1_pend", rf_pending_o, 32'h18);
    check_eq("cap1_outld", outstanding_load_wb_o, 1'b1);
    cyc("captured x4 retires");
    @(negedge clk_i);
    write_chk("cap2", 1'b1, 1'b0, 5'd4, 32'hDEAD_BEEF);
    check_eq("cap2_fwd", rf_wdata_fwd_wb_o, 32'hDEAD_BEEF);
    check_eq("cap2_outld", outstanding_load_wb_o, 1'b0);
    check_perf("cap2", 1'b1, 1'b0, 32'h308);
    cyc("idle");
    @(negedge clk_i);
    check_eq("cap3_done", instr_done_wb_o, 1'b0);

    // Errored load
    cyc("enq LOAD x7");
    enq(WB_INSTR_LOAD, 5'd7, 32'd0, 1'b0, 32'h400, 1'b0);
    cyc("wait");
    @(negedge clk_i);
    check_eq("err0_pend", rf_pending_o, 32'h80);
    cyc("error resp x7");
    resp(32'h5555_5555, 1'b1);
    @(negedge clk_i);
    write_chk("err1", 1'b0, 1'b0, 5'd7, 32'h5555_5555);
    check_perf("err1", 1'b0, 1'b0, 32'h400);
    cyc("idle");
    @(negedge clk_i);
    check_eq("err2_pend", rf_pending_o, 32'd0);

    // FP load f2
    cyc("enq FP LOAD f2");
    enq(WB_INSTR_LOAD, 5'd2, 32'd0, 1'b1, 32'h500, 1'b1);
    cyc("wait");
    @(negedge clk_i);
    check_eq("fp0_fppend", fp_rf_pending_o, 32'h4);
    check_eq("fp0_pend", rf_pending_o, 32'd0);
    cyc("resp f2");
    resp(32'h3F80_0000, 1'b0);
    @(negedge clk_i);
    write_chk("fp1", 1'b0, 1'b1, 5'd2, 32'h3F80_0000);
    check_perf("fp1", 1'b1, 1'b1, 32'h500);
    cyc("idle");
    @(negedge clk_i);
    check_eq("fp2_fppend", fp_rf_pending_o, 32'd0);

    // Store never writes
    cyc("enq STORE x8");
    enq(WB_INSTR_STORE, 5'd8, 32'h88, 1'b0, 32'h600, 1'b0);
    cyc("wait");
    @(negedge clk_i);
    check_eq("st0_outst", outstanding_store_wb_o, 1'b1);
    check_eq("st0_pend", rf_pending_o, 32'd0);
    cyc("resp store");
    resp(32'h0, 1'b0);
    @(negedge clk_i);
    write_chk("st1", 1'b0, 1'b0, 5'd8, 32'h0);

    // Reset mid-operation
    cyc("enq LOAD x10");
    enq(WB_INSTR_LOAD, 5'd10, 32'd0, 1'b0, 32'h700, 1'b0);
    cyc("enq LOAD x11");
    enq(WB_INSTR_LOAD, 5'd11, 32'd0, 1'b0, 32'h704, 1'b0);
    cyc("full");
    @(negedge clk_i);
    check_eq("mr0_ready", ready_wb_o, 1'b0);
    check_eq("mr0_pend", rf_pending_o, 32'hC00);
    cyc("assert reset");
    rst_ni = 1'b0;
    cyc("release, stale resp");
    rst_ni = 1'b1;
    resp(32'hBAD0_BAD0, 1'b0);
    @(negedge clk_i);
    check_eq("mr1_we", rf_we_wb_o, 1'b0);
    check_eq("mr1_done", instr_done_wb_o, 1'b0);
    check_eq("mr1_pend", rf_pending_o, 32'd0);
    check_eq("mr1_ready", ready_wb_o, 1'b1);
    check_eq("mr1_outld", outstanding_load_wb_o, 1'b0);
    cyc("stale resp");
    resp(32'hBAD1_BAD1, 1'b0);
    @(negedge clk_i);
    check_eq("mr2_we", rf_we_wb_o, 1'b0);
    check_eq("mr2_wdata", rf_wdata_wb_o, 32'd0);
    cyc("enq OTHER x1");
    enq(WB_INSTR_OTHER, 5'd1, 32'h11, 1'b0, 32'h800, 1'b0);
    cyc("x1 retires");
    @(negedge clk_i);
    write_chk("mr3", 1'b1, 1'b0, 5'd1, 32'h11);

    cyc("end");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
